// File: rtl/mac_sequencer.sv
// Dot-product sequencer driving an external d = a*b + c multiply-add datapath.
// Optional build macro MAC_SEQ_SATURATE_EN: saturate the accumulator instead of wrapping.
module mac_sequencer #(
   parameter int LEN_W = 4,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   output logic             in_ready,
   output logic [7:0]       ma_a,
   output logic [7:0]       ma_b,
   output logic [ACC_W-1:0] ma_c,
   input  logic [ACC_W-1:0] ma_d,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] result,
   output logic             ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             w_transfer;
   logic             w_last;
   logic             w_wrap;
   logic [ACC_W-1:0] w_acc_upd;
   logic [ACC_W-1:0] r_acc;
   logic [LEN_W-1:0] r_remaining;
   logic [ACC_W-1:0] r_result;
   logic             r_ovf;

   // a*b never exceeds 0xFE01, so a sum smaller than the old addend means a wrap.
   assign w_wrap = (ma_d < r_acc);

`ifdef MAC_SEQ_SATURATE_EN
   assign w_acc_upd = (w_wrap || (r_acc == '1)) ? '1 : ma_d;
`else
   assign w_acc_upd = ma_d;
`endif

   assign w_transfer = (r_state == S_RUN) && in_valid;
   assign w_last     = (r_remaining == LEN_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns w_next_state and no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = (len != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (w_transfer && w_last) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_remaining <= '0;
         r_result    <= '0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc       <= '0;
                  r_ovf       <= 1'b0;
                  r_remaining <= len;
                  if (len == '0) begin
                     r_result <= '0;
                  end
               end
            end
            S_RUN: begin
               if (w_transfer) begin
                  r_acc       <= w_acc_upd;
                  r_remaining <= r_remaining - LEN_W'(1);
                  r_ovf       <= r_ovf | w_wrap;
                  // Result is captured on entry to DONE so it is valid alongside done.
                  if (w_last) begin
                     r_result <= w_acc_upd;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready = (r_state == S_RUN);
   assign ma_a     = (r_state == S_RUN) ? in_a : 8'h00;
   assign ma_b     = (r_state == S_RUN) ? in_b : 8'h00;
   assign ma_c     = r_acc;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign result   = r_result;
   assign ovf      = r_ovf;

endmodule
